// File: rtl/clock_disp_pkg.sv
// Shared constants and types for the multiplexed HH:MM:SS seven-segment scanner.
// Segment codes are active-low in {g,f,e,d,c,b,a} order.
package clock_disp_pkg;

    localparam int NUM_DIGITS = 6;

    typedef logic [2:0] digit_idx_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam logic [6:0] SEG_FONT [10] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    // Anything outside 0..9 renders dark rather than indexing past the table.
    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        if (digit > 4'd9) begin
            return SEG_OFF;
        end
        return SEG_FONT[digit];
    endfunction

endpackage

// File: rtl/bin_to_bcd.sv
// Combinational split of a 6-bit value (0..63) into decimal tens and ones digits.
module bin_to_bcd (
    input  logic [5:0] bin_i,
    output logic [3:0] tens_o,
    output logic [3:0] ones_o
);

    assign tens_o = 4'(bin_i / 6'd10);
    assign ones_o = 4'(bin_i % 6'd10);

endmodule

// File: rtl/clock_display_scan.sv
// Six-digit multiplexed seven-segment scanner with per-frame time snapshot, anode blanking
// and blinking colon. Define CLOCK_DISPLAY_HOUR12_EN for 12-hour display with a PM dot.
module clock_display_scan
    import clock_disp_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int SCAN_HZ      = 1_000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic [5:0] sec,
    input  logic [5:0] min,
    input  logic [4:0] hour,
    output logic [6:0] seg,
    output logic       dp,
    output logic [5:0] an
);

    localparam int DIV = CLK_HZ / SCAN_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PCNT_LAST = PW'(DIV - 1);
    localparam logic [PW-1:0] BLANK_END = PW'(BLANK_CYCLES);
    localparam digit_idx_t    IDX_LAST  = digit_idx_t'(NUM_DIGITS - 1);

    logic [PW-1:0] pcnt_q, pcnt_d;
    digit_idx_t    idx_q, idx_d;
    logic [5:0]    snap_sec_q, snap_sec_d;
    logic [5:0]    snap_min_q, snap_min_d;
    logic [4:0]    snap_hour_q, snap_hour_d;
    logic          blink_q, blink_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic [5:0]    an_q, an_d;

    logic          strobe;
    logic [4:0]    hour_shown;
    logic [3:0]    sec_tens, sec_ones, min_tens, min_ones, hour_tens, hour_ones;
    logic [3:0]    digit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcnt_q      <= '0;
            idx_q       <= '0;
            snap_sec_q  <= '0;
            snap_min_q  <= '0;
            snap_hour_q <= '0;
            blink_q     <= 1'b0;
            seg_q       <= SEG_OFF;
            dp_q        <= 1'b1;
            an_q        <= 6'h3F;
        end else begin
            pcnt_q      <= pcnt_d;
            idx_q       <= idx_d;
            snap_sec_q  <= snap_sec_d;
            snap_min_q  <= snap_min_d;
            snap_hour_q <= snap_hour_d;
            blink_q     <= blink_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            an_q        <= an_d;
        end
    end

    // The snapshot shares the idx 5 -> 0 edge so a whole frame shows one coherent time.
    always_comb begin
        strobe      = (pcnt_q == PCNT_LAST);
        pcnt_d      = strobe ? '0 : pcnt_q + 1'b1;
        idx_d       = idx_q;
        snap_sec_d  = snap_sec_q;
        snap_min_d  = snap_min_q;
        snap_hour_d = snap_hour_q;
        blink_d     = blink_q ^ tick;
        if (strobe) begin
            if (idx_q == IDX_LAST) begin
                idx_d       = '0;
                snap_sec_d  = sec;
                snap_min_d  = min;
                snap_hour_d = hour;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_comb begin
`ifdef CLOCK_DISPLAY_HOUR12_EN
        if (snap_hour_q == 5'd0) begin
            hour_shown = 5'd12;
        end else if (snap_hour_q > 5'd12) begin
            hour_shown = snap_hour_q - 5'd12;
        end else begin
            hour_shown = snap_hour_q;
        end
`else
        hour_shown = snap_hour_q;
`endif
    end

    bin_to_bcd u_bcd_sec  (.bin_i(snap_sec_q),         .tens_o(sec_tens),  .ones_o(sec_ones));
    bin_to_bcd u_bcd_min  (.bin_i(snap_min_q),         .tens_o(min_tens),  .ones_o(min_ones));
    bin_to_bcd u_bcd_hour (.bin_i({1'b0, hour_shown}), .tens_o(hour_tens), .ones_o(hour_ones));

    always_comb begin
        case (idx_q)
            3'd0:    digit = sec_ones;
            3'd1:    digit = sec_tens;
            3'd2:    digit = min_ones;
            3'd3:    digit = min_tens;
            3'd4:    digit = hour_ones;
            3'd5:    digit = hour_tens;
            default: digit = sec_ones;
        endcase
        seg_d = seg_encode(digit);
        dp_d  = ~(((idx_q == 3'd2) || (idx_q == 3'd4)) && blink_q);
`ifdef CLOCK_DISPLAY_HOUR12_EN
        if ((idx_q == 3'd0) && (snap_hour_q >= 5'd12)) begin
            dp_d = 1'b0;
        end
`endif
        an_d = (pcnt_q < BLANK_END) ? 6'h3F : ~(6'd1 << idx_q);
    end

    assign seg = seg_q;
    assign dp  = dp_q;
    assign an  = an_q;

endmodule

// File: tb/tb_clock_display_scan.sv
// Directed bench for clock_display_scan (DIV=10, BLANK_CYCLES=2) with a cycle-count model of
// the scan and literal spot checks on fonts, anode timing, colon and reset behaviour.
module tb_clock_display_scan;

    localparam int CLK_HZ  = 1000;
    localparam int SCAN_HZ = 100;
    localparam int BLANK   = 2;
    localparam int DIV     = CLK_HZ / SCAN_HZ;
    localparam int FRAME   = 6 * DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic [5:0] sec = 6'd56;
    logic [5:0] min = 6'd34;
    logic [4:0] hour = 5'd12;
    logic [6:0] seg;
    logic       dp;
    logic [5:0] an;

    int n_checks = 0;
    int n_fail   = 0;

    clock_display_scan #(
        .CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ), .BLANK_CYCLES(BLANK)
    ) dut (
        .clk(clk), .reset(rst), .tick(tick),
        .sec(sec), .min(min), .hour(hour),
        .seg(seg), .dp(dp), .an(an)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] font(input int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic int hour_shown(input int h);
`ifdef CLOCK_DISPLAY_HOUR12_EN
        if (h == 0) return 12;
        if (h > 12) return h - 12;
        return h;
`else
        return h;
`endif
    endfunction

    // n counts clock cycles since reset release; slot and in-slot position follow from it.
    function automatic logic [5:0] model_an(input int n);
        if ((n % DIV) < BLANK) return 6'h3F;
        return ~(6'd1 << ((n / DIV) % 6));
    endfunction

    function automatic logic [6:0] model_seg(input int n, input int s, input int m, input int h);
        int hs;
        hs = hour_shown(h);
        case ((n / DIV) % 6)
            0: return font(s % 10);
            1: return font(s / 10);
            2: return font(m % 10);
            3: return font(m / 10);
            4: return font(hs % 10);
            default: return font(hs / 10);
        endcase
    endfunction

    function automatic logic model_dp(input int n, input int h, input int ticks);
        int slot;
        slot = (n / DIV) % 6;
        if ((slot == 2 || slot == 4) && (ticks % 2 == 1)) return 1'b0;
`ifdef CLOCK_DISPLAY_HOUR12_EN
        if (slot == 0 && h >= 12) return 1'b0;
`endif
        return 1'b1;
    endfunction

    // ---------------- behavioural model ----------------
    int         m_n = 0, m_ticks = 0, m_s = 0, m_m = 0, m_h = 0;
    logic [6:0] exp_seg = 7'h7F;
    logic       exp_dp  = 1'b1;
    logic [5:0] exp_an  = 6'h3F;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_n <= 0; m_ticks <= 0; m_s <= 0; m_m <= 0; m_h <= 0;
            exp_seg <= 7'h7F; exp_dp <= 1'b1; exp_an <= 6'h3F;
        end else begin
            exp_an  <= model_an(m_n);
            exp_seg <= model_seg(m_n, m_s, m_m, m_h);
            exp_dp  <= model_dp(m_n, m_h, m_ticks);
            if (tick) m_ticks <= m_ticks + 1;
            if (m_n % FRAME == FRAME - 1) begin
                m_s <= int'(sec); m_m <= int'(min); m_h <= int'(hour);
            end
            m_n <= m_n + 1;
        end
    end

    // Segments and dp only matter while a digit is lit (or while reset holds them dark).
    always @(negedge clk) begin
        check("an_model", int'(an), int'(exp_an));
        if (rst || exp_an != 6'h3F) begin
            check("seg_model", int'(seg), int'(exp_seg));
            check("dp_model", int'(dp), int'(exp_dp));
        end
    end

    // ---------------- driver tasks ----------------
    // Leaves the current slot if already lit, then waits for digit k to light.
    task automatic wait_slot(input int k);
        int t;
        logic [5:0] pat;
        pat = ~(6'd1 << k);
        t = 0;
        while (an == pat && t < 200) begin @(negedge clk); t++; end
        while (an != pat && t < 200) begin @(negedge clk); t++; end
        if (t >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_slot%0d: an=0x%0h never reached 0x%0h", k, an, pat);
        end
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        #1 rst = 1'b1;
        #2;
        check("rst_an", int'(an), 'h3F);
        check("rst_seg", int'(seg), 'h7F);
        check("rst_dp", int'(dp), 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Anode 0 first lights three cycles after release; frame 0 shows zeros.
        @(negedge clk); check("blank_c1", int'(an), 'h3F);
        @(negedge clk); check("blank_c2", int'(an), 'h3F);
        @(negedge clk); check("an0_c3", int'(an), 'h3E);
        check("zero_digit", int'(seg), 'h40);

        // Frame 1 shows the snapshot of 12:34:56 even after sec changes mid-frame.
        wait_slot(0); check("snap_d0", int'(seg), 'h02);
        sec = 6'd57;
        wait_slot(1); check("snap_d1", int'(seg), 'h12);
        wait_slot(2); check("snap_d2", int'(seg), 'h19);
        wait_slot(3); check("snap_d3", int'(seg), 'h30);
        wait_slot(4); check("snap_d4", int'(seg), 'h24);
        wait_slot(5); check("snap_d5", int'(seg), 'h79);
        wait_slot(0); check("snap_new_d0", int'(seg), 'h78);

        // Colon on idx 2/4 after one tick, gone after the second.
        pulse_tick();
        wait_slot(2); check("colon_on_d2", int'(dp), 0);
        wait_slot(4); check("colon_on_d4", int'(dp), 0);
        wait_slot(5); check("colon_off_d5", int'(dp), 1);
        wait_slot(0); check("colon_off_d0", int'(dp), 1);
        pulse_tick();
        wait_slot(2); check("colon_clr_d2", int'(dp), 1);
        wait_slot(4); check("colon_clr_d4", int'(dp), 1);

        // Out-of-range seconds display arithmetically.
        sec = 6'd63;
        wait_slot(5);
        wait_slot(0); check("sec63_ones", int'(seg), 'h30);
        wait_slot(1); check("sec63_tens", int'(seg), 'h02);

        hour = 5'd13;
        wait_slot(5);
        wait_slot(0);
`ifdef CLOCK_DISPLAY_HOUR12_EN
        check("h13_pm_dp", int'(dp), 0);
        wait_slot(4); check("h13_ones", int'(seg), 'h79);
        wait_slot(5); check("h13_tens", int'(seg), 'h40);
`else
        check("h13_pm_dp", int'(dp), 1);
        wait_slot(4); check("h13_ones", int'(seg), 'h30);
        wait_slot(5); check("h13_tens", int'(seg), 'h79);
`endif

        hour = 5'd0;
        wait_slot(5);
        wait_slot(0); check("h0_pm_dp", int'(dp), 1);
`ifdef CLOCK_DISPLAY_HOUR12_EN
        wait_slot(4); check("h0_ones", int'(seg), 'h24);
        wait_slot(5); check("h0_tens", int'(seg), 'h79);
`else
        wait_slot(4); check("h0_ones", int'(seg), 'h40);
        wait_slot(5); check("h0_tens", int'(seg), 'h40);
`endif

        // Asynchronous reset in the middle of slot 3 darkens outputs at once.
        wait_slot(3);
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_an", int'(an), 'h3F);
        check("midrst_seg", int'(seg), 'h7F);
        check("midrst_dp", int'(dp), 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); check("restart_an0", int'(an), 'h3E);
        check("restart_zero", int'(seg), 'h40);
        wait_slot(5); check("restart_d5", int'(seg), 'h40);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clock_display_scan.md
# clock_display_scan

Multiplexed 6-digit seven-segment driver fed by the HH:MM:SS time counter. Snapshots `hour`/`min`/`sec` once per scan frame and splits each into BCD digits. Scans one digit at a time with anti-ghosting blanking, and drives a blinking colon on the decimal points. Sits directly downstream of the time counter; outputs go straight to board pins.

## Interface
- `CLK_HZ`, default 50_000_000: system clock frequency.
- `SCAN_HZ`, default 1_000: digit-slot rate. Slot length `DIV = CLK_HZ/SCAN_HZ` cycles, with `DIV` ≥ 2.
- `BLANK_CYCLES`, default 16: cycles at the start of each slot with all anodes off. Range 1 ≤ `BLANK_CYCLES` < `DIV`.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high reset. Single clock domain.
- `tick` in 1: 1 Hz single-cycle strobe, same as the counter's advance strobe.
- `sec` in 6: seconds, 0..59.
- `min` in 6: minutes, 0..59.
- `hour` in 5: hours, 0..23.
- `seg` out 7: segments {g,f,e,d,c,b,a}, active-low.
- `dp` out 1: decimal point, active-low.
- `an` out 6: digit anodes, active-low. `an[0]` is the rightmost digit.

## Operation
- **Prescaler** `pcnt` counts 0..DIV-1 and wraps. `strobe` = (`pcnt` == DIV-1).
- **Digit index** `idx` counts 0..5. It advances on `strobe`; 5 wraps to 0.
- **Snapshot:** on `strobe` with `idx` == 5, capture `sec`, `min`, `hour` into `snap_*`. The same edge moves `idx` to 0, so each frame displays one coherent time and never tears.
- **BCD split:** tens = v/10, ones = v%10 for v in 0..63. Out-of-range inputs display arithmetically, e.g. 62 shows "62".
- **Digit map by `idx`:**
  - 0: sec ones
  - 1: sec tens
  - 2: min ones
  - 3: min tens
  - 4: hour ones
  - 5: hour tens
- **Decimal points / colon:**
  - `blink` flip-flop toggles on every `tick`.
  - `dp` is active on `idx` 2 and 4 when `blink` = 1. This forms the HH.MM.SS separators.
  - `dp` is inactive on all other digits, except the PM indicator (see Configuration).
- **Blanking:** while `pcnt` < BLANK_CYCLES, `an` = 6'b111111. Otherwise only `an[idx]` = 0.
- **Output register:** `seg`, `dp` and `an` are registered. They are computed from the current `idx`, `pcnt`, `snap_*` and `blink`.
- **Simultaneous events:** `tick` and `strobe` in the same cycle are both applied independently. Input changes outside the snapshot edge have no effect on the display.

## Timing
- **Reset values:**
  - `seg` = 7'h7F, `dp` = 1, `an` = 6'h3F.
  - `pcnt` = 0, `idx` = 0, `snap_*` = 0, `blink` = 0.
- **Reset mid-scan:** takes effect immediately (asynchronous). Outputs go dark within the same cycle.
- **Output latency:** one cycle from `idx`/`pcnt` to pins.
- **Anode timing:** the anode for slot k is low for DIV-BLANK_CYCLES cycles per slot. The first active cycle is `pcnt` == BLANK_CYCLES, seen on pins one cycle later.
- **Frame length:** 6·DIV cycles. Input-to-display latency ≤ 6·DIV + 1 cycles after the value settles.
- **After reset:** "00:00:00" is shown until the first snapshot at cycle 6·DIV.
- **Colon:** `blink` changes on the edge where `tick` = 1. The visible `dp` follows one cycle later, and only within an active `idx` 2/4 slot.

## Configuration
- Macro `CLOCK_DISPLAY_HOUR12_EN`.
- **Defined:** the hour is shown in 12-hour form.
  - 0 → 12; 1..12 unchanged; 13..23 → h-12.
  - The PM indicator is `dp` active on `idx` 0 when `snap_hour` ≥ 12, independent of `blink`.
- **Undefined:** 24-hour display, with the tens digit shown even when 0. The `idx` 0 `dp` is always inactive.

## Structure
- **Package `clock_disp_pkg`:**
  - `NUM_DIGITS` = 6.
  - `digit_idx_t` (3-bit).
  - `SEG_FONT[10]` active-low segment table.
  - `SEG_OFF` = 7'h7F.
- **Sub-module `bin_to_bcd`:** combinational 6-bit → {tens[3:0], ones[3:0]} for 0..63. Instantiated three times, on `snap_sec`, `snap_min` and the adjusted hour.

## Test plan
- **Reset and blanking:** CLK_HZ=1000, SCAN_HZ=100 (DIV=10), BLANK_CYCLES=2. Assert reset, then release → `an`=3F, `seg`=7F, `dp`=1 while in reset. `an[0]`=0 first appears 3 cycles after release, and `an` walks 0→5 every 10 cycles.
- **Snapshot coherence:** drive 12:34:56, then change `sec` to 57 mid-frame → the current frame still shows digits 6,5,4,3,2,1 with fonts 0x02,0x12,0x19,0x30,0x24,0x79. Digit 0 shows 7 only after the `idx`=5 strobe.
- **Colon blink:** pulse `tick` once → `dp`=0 during `idx` 2 and 4 active slots only. A second `tick` → `dp`=1 everywhere.
- **Out-of-range input:** `sec`=63 → digits 0/1 show 3/6.
- **12-hour mode:** with `CLOCK_DISPLAY_HOUR12_EN` defined:
  - `hour`=0 → hour digits "12" and the `idx` 0 `dp` is inactive.
  - `hour`=13 → "01" and `dp`=0 on `idx` 0.
  - Undefined macro, `hour`=13 → "13".
- **Reset mid-scan:** assert reset at `idx`=3, `pcnt`=5 → outputs dark the same cycle. After release, the scan restarts at `idx` 0 showing 00:00:00.
